// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: read ports, writeback ports, issue handshake and flush.
// Issue handshake: decode holds i_issue_valid/i_issue_rd; an issue is taken on a rising edge where valid && o_issue_ready.
interface regfile_sb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
);
  localparam int AW = $clog2(REG_NUM);

  logic [NUM_RD*AW-1:0]         i_rs_addr;
  logic [NUM_RD*DATA_WIDTH-1:0] o_rs_data;
  logic [NUM_RD-1:0]            o_rs_busy;
  logic [NUM_WR-1:0]            i_wr_en;
  logic [NUM_WR*AW-1:0]         i_wr_addr;
  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data;
  logic                         i_issue_valid;
  logic [AW-1:0]                i_issue_rd;
  logic                         o_issue_ready;
  logic                         i_flush;

  modport slave (
    input  i_rs_addr, i_wr_en, i_wr_addr, i_wr_data, i_issue_valid, i_issue_rd, i_flush,
    output o_rs_data, o_rs_busy, o_issue_ready
  );

  modport master (
    output i_rs_addr, i_wr_en, i_wr_addr, i_wr_data, i_issue_valid, i_issue_rd, i_flush,
    input  o_rs_data, o_rs_busy, o_issue_ready
  );
endinterface

// File: rtl/regfile_sb.sv
// Multi-ported GPR file (x0 hard-wired to zero) with per-register pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data/busy-clear to the read ports.
module regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 2
) (
  input logic         i_clk,
  input logic         i_rst,
  regfile_sb_if.slave bus
);
  localparam int AW = $clog2(REG_NUM);

  logic [DATA_WIDTH-1:0]        regs_q [REG_NUM];
  logic [DATA_WIDTH-1:0]        regs_d [REG_NUM];
  logic [REG_NUM-1:0]           busy_q;
  logic [REG_NUM-1:0]           busy_d;
  logic [AW-1:0]                issue_rd;
  logic                         issue_ready;
  logic [NUM_RD*DATA_WIDTH-1:0] rs_data;
  logic [NUM_RD-1:0]            rs_busy;

  // Ready looks only at the registered busy bit; a same-cycle writeback does not help.
  assign issue_rd    = bus.i_issue_rd;
  assign issue_ready = (issue_rd == '0) || !busy_q[issue_rd];

  always_comb begin : next_state
    regs_d = regs_q;
    busy_d = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (bus.i_wr_en[w] && (bus.i_wr_addr[w*AW +: AW] != '0)) begin
        regs_d[bus.i_wr_addr[w*AW +: AW]] = bus.i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
        busy_d[bus.i_wr_addr[w*AW +: AW]] = 1'b0;
      end
    end
    // Issue set is applied after the writeback clear so it wins on the same register.
    if (bus.i_issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    if (bus.i_flush) begin
      busy_d = '0;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin : read_ports
    rs_data = '0;
    rs_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      if (bus.i_rs_addr[p*AW +: AW] != '0) begin
        rs_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[bus.i_rs_addr[p*AW +: AW]];
        rs_busy[p]                          = busy_q[bus.i_rs_addr[p*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (bus.i_wr_en[w] && (bus.i_wr_addr[w*AW +: AW] == bus.i_rs_addr[p*AW +: AW])) begin
            rs_data[p*DATA_WIDTH +: DATA_WIDTH] = bus.i_wr_data[w*DATA_WIDTH +: DATA_WIDTH];
            rs_busy[p]                          = 1'b0;
          end
        end
`else
        rs_busy[p] = busy_q[bus.i_rs_addr[p*AW +: AW]];
`endif
      end
    end
  end

  assign bus.o_rs_data     = rs_data;
  assign bus.o_rs_busy     = rs_busy;
  assign bus.o_issue_ready = issue_ready;
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: scenario tasks with an expected-read queue per sample.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_sb #(.DATA_WIDTH(DW), .REG_NUM(RN), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_b_q[$];
  logic [DW-1:0] model [RN];
  logic [DW-1:0] ed;
  logic          eb;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    rst               = 1'b0;
    bus.i_rs_addr     = '0;
    bus.i_wr_en       = '0;
    bus.i_wr_addr     = '0;
    bus.i_wr_data     = '0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_rd    = '0;
    bus.i_flush       = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    drive_idle();
  endtask

  task automatic set_rd(input int p, input logic [AW-1:0] a);
    bus.i_rs_addr[p*AW +: AW] = a;
  endtask

  task automatic set_wr(input int w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.i_wr_en[w]            = 1'b1;
    bus.i_wr_addr[w*AW +: AW] = a;
    bus.i_wr_data[w*DW +: DW] = d;
  endtask

  task automatic issue(input logic [AW-1:0] rd);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = rd;
  endtask

  task automatic expect_rd(input logic [DW-1:0] d, input logic b);
    exp_q.push_back(d);
    exp_b_q.push_back(b);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive_idle();
    for (int a = 0; a < RN; a++) begin
      if (a != 0) next_cycle();
      set_rd(0, a[AW-1:0]);
      set_rd(1, 5'(RN - 1 - a));
      bus.i_issue_rd = a[AW-1:0];
      expect_rd('0, 1'b0);
      expect_rd('0, 1'b0);
      #2;
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL reset_read a=%0d p%0d: data %h busy %b, expected %h busy %b",
                   a, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
      checks++;
      if (bus.o_issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_ready a=%0d: got %b expected 1", a, bus.o_issue_ready);
      end
    end
    next_cycle();
    set_wr(0, 5'd0, 32'hDEADBEEF);
    next_cycle();
    set_rd(0, 5'd0);
    set_rd(1, 5'd0);
    expect_rd('0, 1'b0);
    expect_rd('0, 1'b0);
    #2;
    for (int p = 0; p < NR; p++) begin
      ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
      checks++;
      if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
        errors++;
        $display("FAIL x0_write p%0d: data %h busy %b, expected %h busy %b",
                 p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
      end
    end
  endtask

  task automatic test_write_bypass();
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      if (c == 0) begin
        set_wr(0, 5'd5, 32'h12345678);
        set_rd(0, 5'd7);
        set_rd(1, 5'd5);
        expect_rd('0, 1'b0);
        expect_rd(BYPASS ? 32'h12345678 : 32'h0, 1'b0);
      end else begin
        set_rd(0, 5'd5);
        set_rd(1, 5'd5);
        expect_rd(32'h12345678, 1'b0);
        expect_rd(32'h12345678, 1'b0);
      end
      #2;
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL write_x5 c%0d p%0d: data %h busy %b, expected %h busy %b",
                   c, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
    end
  endtask

  task automatic test_same_addr();
    next_cycle();
    set_wr(0, 5'd7, 32'hAAAA0000);
    set_wr(1, 5'd7, 32'h0000BBBB);
    next_cycle();
    set_rd(0, 5'd7);
    set_rd(1, 5'd7);
    expect_rd(32'h0000BBBB, 1'b0);
    expect_rd(32'h0000BBBB, 1'b0);
    #2;
    for (int p = 0; p < NR; p++) begin
      ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
      checks++;
      if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
        errors++;
        $display("FAIL same_addr p%0d: data %h busy %b, expected %h busy %b",
                 p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic exp_ready;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      set_rd(0, 5'd3);
      set_rd(1, 5'd3);
      bus.i_issue_rd = 5'd3;
      case (c)
        0: begin issue(5'd3); exp_ready = 1'b1;
             expect_rd('0, 1'b0); expect_rd('0, 1'b0); end
        1: begin issue(5'd3); exp_ready = 1'b0;
             expect_rd('0, 1'b1); expect_rd('0, 1'b1); end
        2: begin set_wr(0, 5'd3, 32'h55); exp_ready = 1'b0;
             expect_rd(BYPASS ? 32'h55 : 32'h0, !BYPASS);
             expect_rd(BYPASS ? 32'h55 : 32'h0, !BYPASS); end
        3: begin exp_ready = 1'b1;
             expect_rd(32'h55, 1'b0); expect_rd(32'h55, 1'b0); end
        4: begin issue(5'd3); set_wr(1, 5'd3, 32'h66); exp_ready = 1'b1;
             expect_rd(BYPASS ? 32'h66 : 32'h55, 1'b0);
             expect_rd(BYPASS ? 32'h66 : 32'h55, 1'b0); end
        default: begin exp_ready = 1'b0;
             expect_rd(32'h66, 1'b1); expect_rd(32'h66, 1'b1); end
      endcase
      #2;
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL scoreboard c%0d p%0d: data %h busy %b, expected %h busy %b",
                   c, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
      checks++;
      if (bus.o_issue_ready !== exp_ready) begin
        errors++;
        $display("FAIL scoreboard_ready c%0d: got %b expected %b", c, bus.o_issue_ready, exp_ready);
      end
    end
    next_cycle();
    set_wr(0, 5'd3, 32'h66);
  endtask

  task automatic test_flush();
    logic exp_ready;
    next_cycle();
    issue(5'd9);
    bus.i_flush = 1'b1;
    next_cycle();
    set_wr(0, 5'd4, 32'h44);
    set_wr(1, 5'd6, 32'h66);
    next_cycle();
    issue(5'd4);
    for (int c = 0; c < 4; c++) begin
      next_cycle();
      case (c)
        0: begin set_rd(0, 5'd9); set_rd(1, 5'd9); bus.i_issue_rd = 5'd9; exp_ready = 1'b1;
             expect_rd('0, 1'b0); expect_rd('0, 1'b0); end
        1: begin issue(5'd6); set_rd(0, 5'd4); set_rd(1, 5'd6); exp_ready = 1'b1;
             expect_rd(32'h44, 1'b1); expect_rd(32'h66, 1'b0); end
        2: begin bus.i_flush = 1'b1; set_rd(0, 5'd4); set_rd(1, 5'd6);
             bus.i_issue_rd = 5'd6; exp_ready = 1'b0;
             expect_rd(32'h44, 1'b1); expect_rd(32'h66, 1'b1); end
        default: begin set_rd(0, 5'd4); set_rd(1, 5'd6); bus.i_issue_rd = 5'd4; exp_ready = 1'b1;
             expect_rd(32'h44, 1'b0); expect_rd(32'h66, 1'b0); end
      endcase
      #2;
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL flush c%0d p%0d: data %h busy %b, expected %h busy %b",
                   c, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
      checks++;
      if (bus.o_issue_ready !== exp_ready) begin
        errors++;
        $display("FAIL flush_ready c%0d: got %b expected %b", c, bus.o_issue_ready, exp_ready);
      end
    end
  endtask

  task automatic test_reset_override();
    next_cycle();
    set_wr(0, 5'd10, 32'h1);
    for (int c = 0; c < 2; c++) begin
      next_cycle();
      if (c == 0) begin
        set_rd(0, 5'd10); set_rd(1, 5'd10);
        expect_rd(32'h1, 1'b0); expect_rd(32'h1, 1'b0);
        #2;
      end else begin
        set_rd(0, 5'd10); set_rd(1, 5'd5);
        bus.i_issue_rd = 5'd10;
        expect_rd('0, 1'b0); expect_rd('0, 1'b0);
        #2;
        checks++;
        if (bus.o_issue_ready !== 1'b1) begin
          errors++;
          $display("FAIL rst_override_ready: got %b expected 1", bus.o_issue_ready);
        end
      end
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL rst_override c%0d p%0d: data %h busy %b, expected %h busy %b",
                   c, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
      if (c == 0) begin
        next_cycle();
        rst = 1'b1;
        set_wr(0, 5'd10, 32'h2);
        issue(5'd10);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] wa [NW];
    logic [DW-1:0] wd [NW];
    logic          we [NW];
    logic [AW-1:0] ra;
    logic [DW-1:0] e;
    for (int i = 0; i < RN; i++) model[i] = '0;
    for (int it = 0; it < 40; it++) begin
      next_cycle();
      for (int w = 0; w < NW; w++) begin
        we[w] = ($urandom_range(0, 3) != 0);
        wa[w] = AW'($urandom_range(0, RN - 1));
        wd[w] = $urandom;
        if (we[w]) set_wr(w, wa[w], wd[w]);
      end
      for (int p = 0; p < NR; p++) begin
        ra = (it % 4 == 0 && we[NW-1]) ? wa[NW-1] : AW'($urandom_range(0, RN - 1));
        set_rd(p, ra);
        e = (ra == '0) ? '0 : model[ra];
        if (BYPASS && ra != '0)
          for (int w = 0; w < NW; w++) if (we[w] && wa[w] == ra) e = wd[w];
        expect_rd(e, 1'b0);
      end
      for (int w = 0; w < NW; w++) if (we[w] && wa[w] != '0) model[wa[w]] = wd[w];
      #2;
      for (int p = 0; p < NR; p++) begin
        ed = exp_q.pop_front(); eb = exp_b_q.pop_front();
        checks++;
        if (bus.o_rs_data[p*DW +: DW] !== ed || bus.o_rs_busy[p] !== eb) begin
          errors++;
          $display("FAIL back_to_back it%0d p%0d: data %h busy %b, expected %h busy %b",
                   it, p, bus.o_rs_data[p*DW +: DW], bus.o_rs_busy[p], ed, eb);
        end
      end
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_write_bypass();
    test_same_addr();
    test_scoreboard();
    test_flush();
    test_reset_override();
    test_back_to_back();
    next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
